// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared state encoding, default widths and a small
// modulo helper used by the mult_share_scheduler block and its arbiter.
package mult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int DEF_WIDTH_IN       = 8;
  localparam int DEF_WIDTH_OUT      = 16;
  localparam int DEF_TIMEOUT_CYCLES = 300;

  // (base + off) mod n, valid when base < n and off < n.
  function automatic int wrap_add(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    return (sum >= n) ? sum - n : sum;
  endfunction

endpackage

// File: rtl/mult_share_scheduler_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin picker. Searches the request
// vector starting at ptr_i and wrapping; the first set bit wins. The pointer
// register itself lives in the parent.
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_oh_o,
  output logic [ID_W-1:0]    grant_idx_o,
  output logic               any_req_o
);

  logic [ID_W-1:0] idx;

  // Scan from the pointer upward; the first hit is latched by any_req_o.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    grant_oh_o  = '0;
    grant_idx_o = '0;
    any_req_o   = 1'b0;
    idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'(wrap_add(int'(ptr_i), k, NUM_REQ));
      if (!any_req_o && req_i[idx]) begin
        any_req_o   = 1'b1;
        grant_idx_o = idx;
      end
    end
    if (any_req_o) begin
      grant_oh_o[grant_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/mult_share_scheduler.sv
// mult_share_scheduler: shares one iterative multiplier between NUM_REQ
// requesters. Round-robin grant in IDLE, one-cycle start in ISSUE, wait for
// the done pulse in WAIT, hold the tagged response in RESP until accepted.
// Operands with a zero factor skip the multiplier and answer directly.
// Optional watchdog in WAIT: define MULT_SCHED_TIMEOUT_EN.
module mult_share_scheduler
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH_IN       = DEF_WIDTH_IN,
  parameter int WIDTH_OUT      = DEF_WIDTH_OUT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*WIDTH_IN-1:0]  req_a,
  input  logic [NUM_REQ*WIDTH_IN-1:0]  req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [WIDTH_OUT-1:0]         rsp_product,
  output logic                         rsp_err,
  output logic                         mul_start,
  output logic [WIDTH_IN-1:0]          mul_a,
  output logic [WIDTH_IN-1:0]          mul_b,
  input  logic                         mul_done,
  input  logic [WIDTH_OUT-1:0]         mul_product
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [WIDTH_IN-1:0]  a_q, a_d;
  logic [WIDTH_IN-1:0]  b_q, b_d;
  logic [WIDTH_OUT-1:0] product_q, product_d;

  logic [NUM_REQ-1:0]   grant_oh;
  logic [ID_W-1:0]      grant_idx;
  logic                 any_req;
  logic [WIDTH_IN-1:0]  sel_a;
  logic [WIDTH_IN-1:0]  sel_b;

`ifdef MULT_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  // The watchdog limit only matters when the timeout feature is built in.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_oh_o  (grant_oh),
    .grant_idx_o (grant_idx),
    .any_req_o   (any_req)
  );

  assign sel_a = req_a[grant_idx*WIDTH_IN +: WIDTH_IN];
  assign sel_b = req_b[grant_idx*WIDTH_IN +: WIDTH_IN];

  // Accept is offered only in IDLE and never while reset is asserted.
  assign req_ready   = (state_q == IDLE && !RST) ? grant_oh : '0;
  assign mul_start   = (state_q == ISSUE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_id      = id_q;
  assign rsp_product = product_q;
  assign mul_a       = a_q;
  assign mul_b       = b_q;
`ifdef MULT_SCHED_TIMEOUT_EN
  assign rsp_err     = err_q;
`else
  assign rsp_err     = 1'b0;
`endif

  // Next-state and datapath capture; holds everything by default.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    product_d = product_q;
`ifdef MULT_SCHED_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          a_d  = sel_a;
          b_d  = sel_b;
          id_d = grant_idx;
`ifdef MULT_SCHED_TIMEOUT_EN
          err_d = 1'b0;
`endif
          if (sel_a == '0 || sel_b == '0) begin
            product_d = '0;
            state_d   = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef MULT_SCHED_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      WAIT: begin
        if (mul_done) begin
          product_d = mul_product;
          state_d   = RESP;
        end
`ifdef MULT_SCHED_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          product_d = '0;
          err_d     = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          rr_ptr_d = ID_W'(wrap_add(int'(id_q), 1, NUM_REQ));
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (RST) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      product_q <= '0;
`ifdef MULT_SCHED_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      id_q      <= id_d;
      a_q       <= a_d;
      b_q       <= b_d;
      product_q <= product_d;
`ifdef MULT_SCHED_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

endmodule
